// File: rtl/vi_status_filt_if.sv
// Status-filter signal bundle: producer side (master) drives the raw bus and
// CSR strobes, the filter (slave) returns committed state, stickies and irq.
interface vi_status_filt_if #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
);
  logic [SIZE-1:0]  in_bus;
  logic [SIZE-1:0]  irq_mask;
  logic             clr_wr;
  logic [SIZE-1:0]  clr_data;
  logic             cnt_clr;
  logic [SIZE-1:0]  filt_bus;
  logic [SIZE-1:0]  rise_sticky;
  logic [SIZE-1:0]  fall_sticky;
  logic             irq;
  logic [CNT_W-1:0] chg_cnt;
  logic             settling;

  modport master (
    output in_bus, irq_mask, clr_wr, clr_data, cnt_clr,
    input  filt_bus, rise_sticky, fall_sticky, irq, chg_cnt, settling
  );

  modport slave (
    input  in_bus, irq_mask, clr_wr, clr_data, cnt_clr,
    output filt_bus, rise_sticky, fall_sticky, irq, chg_cnt, settling
  );
endinterface

// File: rtl/vi_status_filt.sv
// Stability filter for a skewed synchronized status bus: commits the bus once
// it holds for STABLE_CYCLES samples, tracking sticky edges, irq and a change count.
module vi_status_filt #(
  parameter int SIZE          = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input logic              clk,
  input logic              rst_n,
  vi_status_filt_if.slave  sf
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);

  typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SIZE-1:0]  in_p0;
  logic [SIZE-1:0]  cand, cand_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             commit;
  logic [SIZE-1:0]  filt_q, filt_nxt;
  logic [SIZE-1:0]  rise_q, rise_nxt;
  logic [SIZE-1:0]  fall_q, fall_nxt;
  logic [CNT_W-1:0] chg_q, chg_nxt;
  logic             irq_q;
  logic             settling_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      STABLE: begin
        if (in_p0 != filt_q) begin
          state_nxt = SETTLE;
          cand_nxt  = in_p0;
          cnt_nxt   = CW'(1);
        end
      end
      SETTLE: begin
        if (in_p0 == filt_q) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (in_p0 != cand) begin
          cand_nxt = in_p0;
          cnt_nxt  = CW'(1);
        end else if (cnt == CNT_DONE) begin
          commit    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clear is applied first and the commit OR'd on top, so a same-cycle set survives.
  always_comb begin
    filt_nxt = commit ? cand : filt_q;
    rise_nxt = (sf.clr_wr ? (rise_q & ~sf.clr_data) : rise_q)
             | (commit ? (cand & ~filt_q) : '0);
    fall_nxt = (sf.clr_wr ? (fall_q & ~sf.clr_data) : fall_q)
             | (commit ? (~cand & filt_q) : '0);
    if (sf.cnt_clr)
      chg_nxt = commit ? CNT_W'(1) : '0;
    else if (commit)
      chg_nxt = sat_inc(chg_q);
    else
      chg_nxt = chg_q;
  end

  // Capture stage p0 feeds the FSM; all outputs register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p0      <= '0;
      state      <= STABLE;
      cand       <= '0;
      cnt        <= '0;
      filt_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      chg_q      <= '0;
      irq_q      <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      in_p0      <= sf.in_bus;
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      filt_q     <= filt_nxt;
      rise_q     <= rise_nxt;
      fall_q     <= fall_nxt;
      chg_q      <= chg_nxt;
      irq_q      <= |((rise_nxt | fall_nxt) & sf.irq_mask);
      settling_q <= (state_nxt == SETTLE);
    end
  end

  assign sf.filt_bus    = filt_q;
  assign sf.rise_sticky = rise_q;
  assign sf.fall_sticky = fall_q;
  assign sf.chg_cnt     = chg_q;
  assign sf.irq         = irq_q;
  assign sf.settling    = settling_q;

endmodule

// File: tb/tb_vi_status_filt.sv
// Bench for vi_status_filt: commit events are scoreboarded with their expected
// edge; irq, settling, saturation and reset behaviour are checked directly.
module tb_vi_status_filt;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  int unsigned cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vi_status_filt_if #(.SIZE(8), .CNT_W(16)) sf1 ();
  vi_status_filt_if #(.SIZE(8), .CNT_W(2))  sf2 ();

  vi_status_filt #(.SIZE(8), .STABLE_CYCLES(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst1_n), .sf(sf1.slave));
  vi_status_filt #(.SIZE(8), .STABLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .sf(sf2.slave));

  typedef struct {
    int unsigned cyc;
    logic [7:0]  filt;
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic [15:0] chg;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int unsigned dly, input logic [7:0] f, input logic [7:0] r,
                      input logic [7:0] fa, input logic [15:0] c);
    exp_t e;
    e.cyc = cyc + dly; e.filt = f; e.rise = r; e.fall = fa; e.chg = c;
    sb_q.push_back(e);
  endtask

  // Step in_bus and expect the commit on the 6th edge after the step.
  task automatic step1(input logic [7:0] v, input logic [7:0] f, input logic [7:0] r,
                       input logic [7:0] fa, input logic [15:0] c);
    sf1.in_bus = v;
    push(6, f, r, fa, c);
    tick(6);
  endtask

  task automatic clr1(input logic [7:0] d, input logic [7:0] f, input logic [7:0] r,
                      input logic [7:0] fa, input logic [15:0] c);
    sf1.clr_wr = 1'b1; sf1.clr_data = d;
    push(1, f, r, fa, c);
    tick(1);
    sf1.clr_wr = 1'b0; sf1.clr_data = '0;
  endtask

  // Monitor: any change in committed state on dut1 must match the head of the queue.
  logic [39:0] prev_snap = '0;
  always @(negedge clk) begin
    logic [39:0] snap;
    exp_t e;
    snap = {sf1.filt_bus, sf1.rise_sticky, sf1.fall_sticky, sf1.chg_cnt};
    if (rst1_n && snap != prev_snap) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got filt=%h rise=%h fall=%h chg=%0d at edge %0d, required no change",
                 sf1.filt_bus, sf1.rise_sticky, sf1.fall_sticky, sf1.chg_cnt, cyc);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.cyc || sf1.filt_bus !== e.filt || sf1.rise_sticky !== e.rise ||
            sf1.fall_sticky !== e.fall || sf1.chg_cnt !== e.chg) begin
          n_fail++;
          $display("FAIL sb_event: got edge %0d filt=%h rise=%h fall=%h chg=%0d, required edge %0d filt=%h rise=%h fall=%h chg=%0d",
                   cyc, sf1.filt_bus, sf1.rise_sticky, sf1.fall_sticky, sf1.chg_cnt,
                   e.cyc, e.filt, e.rise, e.fall, e.chg);
        end
      end
    end
    prev_snap = snap;
  end

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sf1.in_bus = '0; sf1.irq_mask = '0; sf1.clr_wr = 1'b0; sf1.clr_data = '0; sf1.cnt_clr = 1'b0;
    sf2.in_bus = '0; sf2.irq_mask = '0; sf2.clr_wr = 1'b0; sf2.clr_data = '0; sf2.cnt_clr = 1'b0;
    tick(3);
    chk("rst_filt", sf1.filt_bus, 0);
    chk("rst_outs", {sf1.rise_sticky, sf1.fall_sticky, sf1.irq, sf1.settling}, 0);
    chk("rst_chg", sf1.chg_cnt, 0);
    rst1_n = 1'b1;
    tick(2);

    // 1: 0x00 -> 0x3C, settling high edges 2..5, low after commit edge 6
    sf1.in_bus = 8'h3C;
    push(6, 8'h3C, 8'h3C, 8'h00, 16'd1);
    tick(1); chk("t1_settle_e1", sf1.settling, 0);
    tick(1); chk("t1_settle_e2", sf1.settling, 1);
    tick(3); chk("t1_settle_e5", sf1.settling, 1);
    chk("t1_filt_e5", sf1.filt_bus, 8'h00);
    tick(1); chk("t1_settle_e6", sf1.settling, 0);
    chk("t1_irq_masked", sf1.irq, 0);
    tick(2);

    // 2: return to 0, clear, then skewed 0x01 -> 0x03
    step1(8'h00, 8'h00, 8'h3C, 8'h3C, 16'd2);
    clr1(8'hFF, 8'h00, 8'h00, 8'h00, 16'd2);
    tick(1);
    sf1.in_bus = 8'h01;
    tick(1);
    step1(8'h03, 8'h03, 8'h03, 8'h00, 16'd3);
    tick(2);

    // 3: glitch 0x0F -> 0x0E for 2 cycles -> 0x0F, no commit expected
    step1(8'h0F, 8'h0F, 8'h0F, 8'h00, 16'd4);
    tick(1);
    sf1.in_bus = 8'h0E;
    tick(2);
    sf1.in_bus = 8'h0F;
    tick(10);
    chk("t3_settling", sf1.settling, 0);
    chk("t3_filt", sf1.filt_bus, 8'h0F);

    // 4: masked irq, mask change, clear, irq on sticky-set edge
    clr1(8'hFF, 8'h0F, 8'h00, 8'h00, 16'd4);
    step1(8'h00, 8'h00, 8'h00, 8'h0F, 16'd5);
    clr1(8'hFF, 8'h00, 8'h00, 8'h00, 16'd5);
    sf1.irq_mask = 8'h01;
    step1(8'h02, 8'h02, 8'h02, 8'h00, 16'd6);
    tick(1);
    chk("t4_irq_masked", sf1.irq, 0);
    sf1.irq_mask = 8'h02;
    chk("t4_irq_mask_lag", sf1.irq, 0);
    tick(1);
    chk("t4_irq_unmasked", sf1.irq, 1);
    clr1(8'h02, 8'h02, 8'h00, 8'h00, 16'd6);
    chk("t4_irq_cleared", sf1.irq, 0);
    step1(8'h00, 8'h00, 8'h00, 8'h02, 16'd7);
    chk("t4_irq_fall", sf1.irq, 1);
    tick(1);

    // 5: clear-all on the commit edge of 0x00 -> 0x80; set wins, fall cleared
    sf1.in_bus = 8'h80;
    push(6, 8'h80, 8'h80, 8'h00, 16'd8);
    tick(5);
    sf1.clr_wr = 1'b1; sf1.clr_data = 8'hFF;
    tick(1);
    sf1.clr_wr = 1'b0; sf1.clr_data = '0;
    chk("t5_irq", sf1.irq, 0);
    sf1.cnt_clr = 1'b1;
    push(1, 8'h80, 8'h80, 8'h00, 16'd0);
    tick(1);
    sf1.cnt_clr = 1'b0;
    tick(3);

    // 6: CNT_W=2 saturation, clear-with-commit, reset mid-SETTLE
    rst2_n = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      sf2.in_bus = (i % 2 == 0) ? 8'h01 : 8'h00;
      tick(7);
      chk($sformatf("t6_sat_%0d", i), sf2.chg_cnt, sat_exp[i]);
    end
    sf2.in_bus = 8'h00;
    tick(5);
    sf2.cnt_clr = 1'b1;
    tick(1);
    sf2.cnt_clr = 1'b0;
    chk("t6_clr_commit", sf2.chg_cnt, 1);
    chk("t6_filt", sf2.filt_bus, 8'h00);
    sf2.in_bus = 8'h01;
    tick(3);
    chk("t6_settling", sf2.settling, 1);
    rst2_n = 1'b0;
    #1;
    chk("t6_rst_async", {sf2.filt_bus, sf2.rise_sticky, sf2.fall_sticky, sf2.irq,
                         sf2.chg_cnt, sf2.settling}, 0);
    tick(2);
    rst2_n = 1'b1;
    tick(5);
    chk("t6_post_rst_e5", sf2.filt_bus, 8'h00);
    tick(1);
    chk("t6_post_rst_filt", sf2.filt_bus, 8'h01);
    chk("t6_post_rst_rise", sf2.rise_sticky, 8'h01);
    chk("t6_post_rst_chg", sf2.chg_cnt, 1);

    tick(2);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
